pwm_sample_feeder: RTL and testbench
====================================

Name: pwm_sample_feeder

Overview:
- Upstream stage of the 4-sample PWM audio output stage.
- Accepts 8-bit PCM samples over a valid/ready stream and buffers them in a word FIFO, packed 4 per 32-bit word.
- Presents one packed word plus the audio enable to the PWM stage, in lockstep with its 1024-cycle frame (4 sub-periods × 256 clocks).
- Handles priming, underrun and orderly stop.

Parameters:
- DEPTH_WORDS, 16, FIFO depth in 32-bit words; power of 2, ≥2.
- PRIME_WORDS, 4, words required in FIFO before playback starts; 1..DEPTH_WORDS.
- SILENCE, 8'h80, sample value replicated ×4 on underrun or when idle.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset, synchronous deassertion assumed upstream.
- play  in  1  level request to play; sampled at frame boundaries.
- s_data  in  8  input sample, unsigned PCM.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept s_data this cycle.
- data_o  out  32  packed word to PWM stage; [31:24] plays first, [7:0] last.
- aud_en_o  out  1  audio enable to PWM stage.
- level_o  out  $clog2(DEPTH_WORDS)+1  FIFO occupancy in words.
- underrun_o  out  1  one-cycle pulse when silence is substituted for a missing word.

Behaviour:
- Reset (rstn=0, asynchronous) clears the FIFO, the pack register and the byte index, and sets:
  - data_o={4{SILENCE}}
  - aud_en_o=0
  - underrun_o=0
  - level_o=0
  - frame_cnt=0
  - state=IDLE
- Packer:
  - A transfer occurs when s_valid && s_ready.
  - 2-bit byte index; byte 0 goes to bits [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - Accepting byte 3 pushes the completed word into the FIFO on the same edge.
  - s_ready = !(byte_idx==3 && fifo_full), with fifo_full evaluated before a same-cycle pop. If the FIFO is full but a pop occurs this cycle, s_ready stays 0 (no bypass).
  - A partial word is retained across IDLE/PLAY transitions; it is never dropped except by reset.
- FIFO:
  - Synchronous, registered read into data_o, DEPTH_WORDS entries.
  - A simultaneous push and pop leaves the level unchanged.
  - No push when full, no pop when empty.
- Frame counter:
  - 10-bit frame_cnt mirrors the PWM stage counter.
  - Rule: frame_cnt <= aud_en_o ? frame_cnt+1 : 0. It wraps 1023→0.
- State machine:
  - IDLE:
    - aud_en_o=0, data_o={4{SILENCE}}.
    - When play && level ≥ PRIME_WORDS: pop the head into data_o, set aud_en_o=1 on the same edge, go to PLAY.
    - The PWM stage thus starts its counter at 0 with the first word already valid.
  - PLAY:
    - At frame_cnt==1023 with play=1, the next word is loaded on the edge where frame_cnt wraps to 0.
    - Word available: pop it into data_o.
    - FIFO empty: data_o <= {4{SILENCE}}, underrun_o=1 for exactly that cycle, stay in PLAY. Playback resumes with real data at the first boundary with a word available; no re-priming.
    - At frame_cnt==1023 with play=0: aud_en_o <= 0, data_o <= {4{SILENCE}}, go to IDLE. The current frame is always completed.
    - A deassertion of play mid-frame takes effect only at the boundary.
- Latency:
  - First sample accepted to audible: at least PRIME_WORDS×4 samples plus 1 clock.
  - Word pop to data_o: 0 cycles; registered on the boundary edge.
- Reset mid-frame: all outputs go to reset values immediately; the PWM stage output is gated low by aud_en_o=0.

Optional Feature:
- Macro: PWM_FEEDER_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt_o [15:0], reset to 0.
  - Increments on each underrun_o pulse and saturates at 16'hFFFF.
  - Cleared by input clr_cnt (1 bit, synchronous, priority over increment).
- When not defined: neither port exists and no counter logic is built. underrun_o behaviour is identical in both builds.

Test Plan:
- Packing order: push 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with play=0 → level_o=2, s_ready=1 throughout, aud_en_o=0, data_o=0x80808080.
- Prime and start (PRIME_WORDS=4):
  - Push 16 samples 0x00..0x0F, then play=1.
  - aud_en_o rises with data_o=0x00010203 on the same edge; level_o 4→3.
  - data_o=0x04050607 exactly 1024 clocks later.
- Underrun:
  - Prime 4 words and play with no further input.
  - After the 4th frame, data_o=0x80808080 and underrun_o pulses once per 1024 clocks; aud_en_o stays 1.
  - Push 4 samples 0xA0..0xA3 → data_o=0xA0A1A2A3 at the next boundary.
- Full backpressure (DEPTH_WORDS=16, play=0): push 64 samples → level_o=16. The 65th..67th samples are accepted; the 68th sees s_ready=0 until a pop occurs.
- Stop: deassert play at frame_cnt=300 → aud_en_o stays 1 until the wrap, falls on the 1023→0 edge, data_o=0x80808080, state IDLE.
- Reset mid-play: rstn=0 at frame_cnt=500 → aud_en_o=0, level_o=0 and data_o=0x80808080 asynchronously. With PWM_FEEDER_UNDERRUN_CNT_EN, underrun_cnt_o=0.

Source files
------------

// File: rtl/pwm_sample_feeder.sv
// rtl/pwm_sample_feeder.sv - sample packer, word FIFO and frame-locked word feeder for the PWM audio stage
// Optional underrun counter built when PWM_FEEDER_UNDERRUN_CNT_EN is defined.
module pwm_sample_feeder #(
  parameter int          DEPTH_WORDS = 16,
  parameter int          PRIME_WORDS = 4,
  parameter logic [7:0]  SILENCE     = 8'h80
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         play,
  input  logic [7:0]                   s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [31:0]                  data_o,
  output logic                         aud_en_o,
  output logic [$clog2(DEPTH_WORDS):0] level_o,
  output logic                         underrun_o
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
  ,
  input  logic                         clr_cnt,
  output logic [15:0]                  underrun_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    byte_idx;
  logic [23:0]   pack_reg;
  logic [9:0]    frame_cnt;
  logic          fifo_full, fifo_empty, push, pop;
  logic          load_silence, aud_en_next, underrun_next;

  assign fifo_full  = (count == (AW+1)'(DEPTH_WORDS));
  assign fifo_empty = (count == '0);
  // Full is judged before any same-cycle pop: no bypass into a slot being freed.
  assign s_ready    = !((byte_idx == 2'd3) && fifo_full);
  assign push       = s_valid && s_ready && (byte_idx == 2'd3);
  assign level_o    = count;

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    load_silence  = 1'b0;
    aud_en_next   = aud_en_o;
    underrun_next = 1'b0;
    case (state)
      IDLE: begin
        if (play && (count >= (AW+1)'(PRIME_WORDS))) begin
          pop         = 1'b1;
          aud_en_next = 1'b1;
          state_next  = PLAY;
        end
      end
      PLAY: begin
        if (frame_cnt == 10'd1023) begin
          if (play) begin
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              load_silence  = 1'b1;
              underrun_next = 1'b1;
            end
          end else begin
            aud_en_next  = 1'b0;
            load_silence = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pack_reg, s_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      byte_idx   <= 2'd0;
      pack_reg   <= '0;
      frame_cnt  <= 10'd0;
      data_o     <= {4{SILENCE}};
      aud_en_o   <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_next;
      aud_en_o   <= aud_en_next;
      underrun_o <= underrun_next;
      // Tracks the PWM stage counter: held at 0 while disabled, free-running when enabled.
      frame_cnt  <= aud_en_o ? frame_cnt + 10'd1 : 10'd0;
      if (s_valid && s_ready) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    pack_reg[23:16] <= s_data;
          2'd1:    pack_reg[15:8]  <= s_data;
          2'd2:    pack_reg[7:0]   <= s_data;
          default: ;
        endcase
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_o <= mem[rd_ptr];
      end else if (load_silence) begin
        data_o <= {4{SILENCE}};
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_cnt_o <= 16'd0;
    end else if (clr_cnt) begin
      underrun_cnt_o <= 16'd0;
    end else if (underrun_o && (underrun_cnt_o != 16'hFFFF)) begin
      underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// tb/tb_pwm_sample_feeder.sv - scoreboard bench for pwm_sample_feeder against a frame-level model
module tb_pwm_sample_feeder;
  localparam int          DEPTH = 16;
  localparam int          PRIME = 4;
  localparam logic [31:0] SIL   = 32'h80808080;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        play = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic [31:0] data_o;
  logic        aud_en_o;
  logic [4:0]  level_o;
  logic        underrun_o;
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
  logic        clr_cnt = 1'b0;
  logic [15:0] underrun_cnt_o;
`endif

  pwm_sample_feeder #(.DEPTH_WORDS(DEPTH), .PRIME_WORDS(PRIME), .SILENCE(8'h80)) dut (
    .clk(clk), .rstn(rstn), .play(play), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .data_o(data_o), .aud_en_o(aud_en_o), .level_o(level_o),
    .underrun_o(underrun_o)
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    , .clr_cnt(clr_cnt), .underrun_cnt_o(underrun_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted bytes and pushed words are held in queues; playback
  // advances one position per clock and consumes a word at each frame start.
  logic [31:0] mq[$];
  logic [7:0]  part[$];
  logic [31:0] m_data = SIL;
  bit          m_en, m_und;
  int          m_pos, m_cnt;
  bit          cap_rstn, cap_play, cap_valid;
  logic [7:0]  cap_data;

  task automatic m_reset();
    mq.delete();
    part.delete();
    m_data = SIL;
    m_en = 0;
    m_und = 0;
    m_pos = 0;
    m_cnt = 0;
  endtask

  function automatic bit m_ready();
    return !(part.size() == 3 && mq.size() == DEPTH);
  endfunction

  task automatic m_edge();
    bit rdy;
    rdy = m_ready();
    if (m_und && m_cnt < 65535) m_cnt++;
    m_und = 0;
    if (!m_en) begin
      if (cap_play && mq.size() >= PRIME) begin
        m_data = mq.pop_front();
        m_en = 1;
        m_pos = 0;
      end
    end else if (m_pos == 1023) begin
      m_pos = 0;
      if (cap_play) begin
        if (mq.size() > 0) m_data = mq.pop_front();
        else begin
          m_data = SIL;
          m_und = 1;
        end
      end else begin
        m_en = 0;
        m_data = SIL;
      end
    end else begin
      m_pos++;
    end
    if (cap_valid && rdy) begin
      part.push_back(cap_data);
      if (part.size() == 4) begin
        mq.push_back({part[0], part[1], part[2], part[3]});
        part.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) m_reset();
    else if (cap_rstn) m_edge();
    chk("data_o", data_o, m_data);
    chk("aud_en_o", {31'd0, aud_en_o}, {31'd0, m_en});
    chk("level_o", {27'd0, level_o}, mq.size());
    chk("underrun_o", {31'd0, underrun_o}, {31'd0, m_und});
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_ready()});
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    chk("underrun_cnt_o", {16'd0, underrun_cnt_o}, m_cnt);
`endif
    cap_rstn  = rstn;
    cap_play  = play;
    cap_valid = s_valid;
    cap_data  = s_data;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    bit done;
    done = 0;
    s_valid = 1'b1;
    s_data = b;
    for (int k = 0; k < 3000 && !done; k++) begin
      acc = s_ready;
      cyc(1);
      if (acc) done = 1;
    end
    if (!done) chk("push_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    bit hit;
    hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      if (m_en && m_pos == p) hit = 1;
      else cyc(1);
    end
    if (!hit) chk("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    cyc(2);
    chk("reset_data", data_o, SIL);
    chk("reset_level", {27'd0, level_o}, 32'd0);
    rstn = 1'b1;
    cyc(1);

    // Packing order with playback off
    for (int i = 1; i <= 8; i++) push_byte(8'(i * 8'h11));
    cyc(2);
    chk("pack_level", {27'd0, level_o}, 32'd2);
    chk("pack_idle_data", data_o, SIL);

    // Prime, start, drain into underrun, recover
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    play = 1'b1;
    cyc(6 * 1024);
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    cyc(2 * 1024 + 10);

    // Stop mid-frame: completes the frame, then idles
    wait_pos(300);
    play = 1'b0;
    cyc(1100);
    chk("stop_aud_en", {31'd0, aud_en_o}, 32'd0);

    // Randomized traffic with varying rates and play toggles
    for (int seg = 0; seg < 10; seg++) begin
      int rate;
      rate = $urandom_range(0, 10);
      if ($urandom_range(0, 1) == 1) play = ~play;
      for (int c = 0; c < 3000; c++) begin
        s_valid = ($urandom_range(0, 999) < rate);
        s_data  = 8'($urandom);
        cyc(1);
      end
    end
    s_valid = 1'b0;
    play = 1'b0;
    cyc(1100);

    // Full backpressure
    do_reset();
    for (int i = 0; i < 67; i++) push_byte(8'(i));
    chk("full_level", {27'd0, level_o}, 32'd16);
    s_valid = 1'b1;
    s_data = 8'h43;
    cyc(5);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    play = 1'b1;
    push_byte(8'h43);
    cyc(4);
    play = 1'b0;

    // Asynchronous reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    play = 1'b1;
    wait_pos(500);
    rstn = 1'b0;
    #1;
    chk("async_aud_en", {31'd0, aud_en_o}, 32'd0);
    chk("async_level", {27'd0, level_o}, 32'd0);
    chk("async_data", data_o, SIL);
`ifdef PWM_FEEDER_UNDERRUN_CNT_EN
    chk("async_cnt", {16'd0, underrun_cnt_o}, 32'd0);
`endif
    play = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
